// File: rtl/cnn_pkg.sv
// Shared fixed-point constants, activation codes, stage payloads and clamp helper
// for the conv post-accumulation datapath.
package cnn_pkg;

  localparam int BITSIZE   = 14;     // signed data width of sum, bias and result
  localparam int FRAC_BITS = 7;      // Q format: 1.0 = 128
  localparam int INV6_Q16  = 10923;  // round(2^16 / 6)

  localparam logic [1:0] ACT_NONE   = 2'b00;
  localparam logic [1:0] ACT_RELU   = 2'b01;
  localparam logic [1:0] ACT_RELU6  = 2'b10;
  localparam logic [1:0] ACT_HSWISH = 2'b11;

  // Wide enough to hold any intermediate the clamp is applied to.
  localparam int CLAMP_W = 48;

  // Stage 1 -> stage 2 payload.
  typedef struct packed {
    logic [BITSIZE-1:0] x;
    logic               sat;
    logic [1:0]         mode;
  } s1_t;

  // Stage 2 -> stage 3 payload; p is x * clamp(x + 3.0, 0, 6.0).
  typedef struct packed {
    logic [BITSIZE-1:0]   x;
    logic [2*BITSIZE-1:0] p;
    logic                 sat;
    logic [1:0]           mode;
  } s2_t;

  // Range check: returns {above hi, below lo}.
  function automatic logic [1:0] sat_range(
    input logic signed [CLAMP_W-1:0] v,
    input logic signed [CLAMP_W-1:0] lo,
    input logic signed [CLAMP_W-1:0] hi
  );
    sat_range = {v > hi, v < lo};
  endfunction

endpackage

// File: rtl/sat_clamp.sv
// Saturating narrow: clamps a signed IN_W value to the signed OUT_W range and
// flags when clamping happened.
module sat_clamp
  import cnn_pkg::*;
#(
  parameter int IN_W  = BITSIZE + 1,
  parameter int OUT_W = BITSIZE
) (
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] dout,
  output logic                    sat
);

  localparam logic signed [CLAMP_W-1:0] ONE   = CLAMP_W'(1);
  localparam logic signed [CLAMP_W-1:0] HI    = (ONE <<< (OUT_W-1)) - ONE;
  localparam logic signed [CLAMP_W-1:0] LO    = -(ONE <<< (OUT_W-1));
  localparam logic signed [OUT_W-1:0]   MAX_V = OUT_W'(HI);
  localparam logic signed [OUT_W-1:0]   MIN_V = OUT_W'(LO);

  logic [1:0] hit;

  // Compare at full width, then pick the rail or the in-range low bits.
  always_comb begin
    hit = sat_range(CLAMP_W'(din), LO, HI);
    if (hit[1])      dout = MAX_V;
    else if (hit[0]) dout = MIN_V;
    else             dout = din[OUT_W-1:0];
    sat = |hit;
  end

endmodule

// File: rtl/bias_act_unit.sv
// Bias add + MobileNetV3 activation (none/ReLU/ReLU6/hard-swish) with saturation.
// Three-stage pipeline under a single global stall; bubbles travel with the data.
module bias_act_unit
  import cnn_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [BITSIZE-1:0] sum_in,
  input  logic signed [BITSIZE-1:0] bias_in,
  input  logic [1:0]                act_mode,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [BITSIZE-1:0] out_data,
  output logic                      out_sat
);

  localparam int STAGES = 3;
  localparam int PW     = 2 * BITSIZE;  // x * c product
  localparam int HW     = PW + 16;      // p * INV6_Q16 product
  localparam int HS_SH  = 16 + FRAC_BITS;

  localparam logic signed [BITSIZE:0]   THREE_X = (BITSIZE+1)'(3 << FRAC_BITS);
  localparam logic signed [BITSIZE:0]   SIX_X   = (BITSIZE+1)'(6 << FRAC_BITS);
  localparam logic signed [BITSIZE-1:0] SIX_FX  = BITSIZE'(6 << FRAC_BITS);
  localparam logic signed [HW-1:0]      INV6_S  = HW'(INV6_Q16);

  logic [STAGES:1] vld_pipe;
  logic            en;
  s1_t             s1;
  s2_t             s2;

  // Whole pipe moves when the output slot is empty or being drained.
  assign en        = !out_valid | out_ready;
  assign in_ready  = en;
  assign out_valid = vld_pipe[STAGES];

  // ---------------- stage 1: bias add, saturate ----------------
  logic signed [BITSIZE:0]   sum_ext;
  logic signed [BITSIZE-1:0] x1_d;
  logic                      sat1_d;

  assign sum_ext = (BITSIZE+1)'(sum_in) + (BITSIZE+1)'(bias_in);

  sat_clamp #(.IN_W(BITSIZE+1), .OUT_W(BITSIZE)) u_sat_bias (
    .din  (sum_ext),
    .dout (x1_d),
    .sat  (sat1_d)
  );

  // ---------------- stage 2: c = clamp(x+3, 0, 6), p = x*c ----------------
  logic signed [BITSIZE-1:0] x1;
  logic signed [BITSIZE:0]   xp3;
  logic signed [BITSIZE:0]   c_d;
  logic signed [PW-1:0]      p_d;

  assign x1 = $signed(s1.x);

  // Hard-swish numerator; c is never negative so the product sign follows x.
  always_comb begin
    xp3 = (BITSIZE+1)'(x1) + THREE_X;
    if (xp3[BITSIZE])     c_d = '0;
    else if (xp3 > SIX_X) c_d = SIX_X;
    else                  c_d = xp3;
    p_d = PW'(x1) * PW'(c_d);
  end

  // ---------------- stage 3: activation select ----------------
  logic signed [BITSIZE-1:0] x2;
  logic signed [PW-1:0]      p2;
  logic signed [HW-1:0]      hs_prod;
  logic signed [HW-1:0]      hs_sh;
  logic signed [BITSIZE-1:0] hs_d;
  logic                      hs_sat;
  logic signed [BITSIZE-1:0] res_d;
  logic                      sat3_d;

  assign x2      = $signed(s2.x);
  assign p2      = $signed(s2.p);
  assign hs_prod = HW'(p2) * INV6_S;
  assign hs_sh   = hs_prod >>> HS_SH;  // arithmetic: floors negatives

  sat_clamp #(.IN_W(HW), .OUT_W(BITSIZE)) u_sat_hswish (
    .din  (hs_sh),
    .dout (hs_d),
    .sat  (hs_sat)
  );

  // Mode mux; only the hard-swish narrow counts as a saturation event here.
  always_comb begin
    res_d  = x2;
    sat3_d = 1'b0;
    case (s2.mode)
      ACT_NONE:  res_d = x2;
      ACT_RELU:  res_d = x2[BITSIZE-1] ? '0 : x2;
      ACT_RELU6: begin
        if (x2[BITSIZE-1])    res_d = '0;
        else if (x2 > SIX_FX) res_d = SIX_FX;
        else                  res_d = x2;
      end
      default: begin
        res_d  = hs_d;
        sat3_d = hs_sat;
      end
    endcase
  end

  // Pipeline registers; reset flushes every stage and clears the output.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      s1       <= '0;
      s2       <= '0;
      out_data <= '0;
      out_sat  <= 1'b0;
    end else if (en) begin
      vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
      s1.x     <= x1_d;
      s1.sat   <= sat1_d;
      s1.mode  <= act_mode;
      s2.x     <= s1.x;
      s2.p     <= p_d;
      s2.sat   <= s1.sat;
      s2.mode  <= s1.mode;
      out_data <= res_d;
      out_sat  <= s2.sat | sat3_d;
    end
  end

endmodule

// File: tb/tb_bias_act_unit.sv
// Directed bench for bias_act_unit: latency, activation values, saturation rails,
// backpressure stall and mid-flight reset.
module tb_bias_act_unit;
  import cnn_pkg::*;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      in_valid;
  logic                      in_ready;
  logic signed [BITSIZE-1:0] sum_in;
  logic signed [BITSIZE-1:0] bias_in;
  logic [1:0]                act_mode;
  logic                      out_valid;
  logic                      out_ready;
  logic signed [BITSIZE-1:0] out_data;
  logic                      out_sat;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bias_act_unit dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sum_in    (sum_in),
    .bias_in   (bias_in),
    .act_mode  (act_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat)
  );

  // Stream vectors: sum, bias, mode, expected data, expected sat (-1 = not checked)
  int         st_sum [10] = '{100, -200, 900, 256, 8000, 500, -100, 768, -8000, 50};
  int         st_bias[10] = '{0,   0,    0,   0,   1000, -100, -50, 0,   -1000, 25};
  logic [1:0] st_mode[10] = '{ACT_NONE, ACT_RELU, ACT_RELU6, ACT_HSWISH, ACT_NONE,
                              ACT_RELU, ACT_RELU6, ACT_HSWISH, ACT_HSWISH, ACT_NONE};
  int         st_exp [10] = '{100, 0, 768, 213, 8191, 400, 0, 768, 0, 75};
  int         st_sat [10] = '{0, 0, -1, 0, 1, 0, 0, 0, 1, 0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One isolated sample: checks out_valid appears exactly on the third edge.
  task automatic send_one(input string tag, input int s, input int b, input logic [1:0] m,
                          input int exp_d, input int exp_s);
    sum_in    = BITSIZE'(s);
    bias_in   = BITSIZE'(b);
    act_mode  = m;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk({tag, "_lat1"}, 32'(out_valid), 0);
    tick();
    chk({tag, "_lat2"}, 32'(out_valid), 0);
    tick();
    chk({tag, "_valid"}, 32'(out_valid), 1);
    chk({tag, "_data"}, 32'($signed(out_data)), exp_d);
    if (exp_s >= 0) chk({tag, "_sat"}, 32'(out_sat), exp_s);
    tick();
  endtask

  initial begin
    int iidx = 0;
    int oidx = 0;
    logic acc;
    logic have_held = 1'b0;
    logic signed [BITSIZE-1:0] held = '0;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    sum_in = '0; bias_in = '0; act_mode = ACT_NONE;
    tick(); tick();
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_data",  32'($signed(out_data)), 0);
    chk("rst_sat",   32'(out_sat), 0);
    chk("rst_ready", 32'(in_ready), 1);
    rst = 1'b0;
    tick();

    send_one("relu_neg",   -378, 0,    ACT_RELU,   0,     0);
    send_one("hs_p3",      384,  0,    ACT_HSWISH, 384,   0);
    send_one("hs_m3",      -384, 0,    ACT_HSWISH, 0,     0);
    send_one("hs_m1",      -128, 0,    ACT_HSWISH, -43,   0);
    send_one("relu6_1000", 1000, 0,    ACT_RELU6,  768,   -1);
    send_one("none_1000",  1000, 0,    ACT_NONE,   1000,  0);
    send_one("sat_pos",    8000, 500,  ACT_NONE,   8191,  1);
    send_one("sat_neg",    -8000, -500, ACT_NONE,  -8192, 1);
    send_one("max_exact",  8191, 0,    ACT_NONE,   8191,  0);

    // Back-to-back stream, output stalled for cycles 4..8.
    for (int cyc = 0; cyc < 60 && oidx < 10; cyc++) begin
      out_ready = !(cyc >= 4 && cyc < 9);
      in_valid  = (iidx < 10);
      if (iidx < 10) begin
        sum_in   = BITSIZE'(st_sum[iidx]);
        bias_in  = BITSIZE'(st_bias[iidx]);
        act_mode = st_mode[iidx];
      end
      #1;
      if (!out_ready) begin
        chk("stall_in_ready", 32'(in_ready), 0);
        if (have_held) chk("stall_hold", 32'($signed(out_data)), 32'($signed(held)));
        held = out_data;
        have_held = 1'b1;
      end
      acc = in_valid && in_ready;
      if (out_valid && out_ready) begin
        chk($sformatf("stream_data%0d", oidx), 32'($signed(out_data)), st_exp[oidx]);
        if (st_sat[oidx] >= 0)
          chk($sformatf("stream_sat%0d", oidx), 32'(out_sat), st_sat[oidx]);
        oidx++;
      end
      tick();
      if (acc) iidx++;
    end
    chk("stream_count", oidx, 10);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick(); tick();
    chk("stream_no_dup", 32'(out_valid), 0);

    // Three samples in flight, then reset.
    for (int k = 0; k < 3; k++) begin
      sum_in = BITSIZE'(1000 + k); bias_in = '0; act_mode = ACT_NONE; in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    chk("midrst_valid", 32'(out_valid), 0);
    chk("midrst_data",  32'($signed(out_data)), 0);
    chk("midrst_sat",   32'(out_sat), 0);
    rst = 1'b0;
    tick();
    chk("flush1_valid", 32'(out_valid), 0);
    tick();
    chk("flush2_valid", 32'(out_valid), 0);
    send_one("post_rst", 123, 0, ACT_NONE, 123, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
